pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 12: number of refclk cycles the PLL reset is held per attempt (1 us at 12 MHz).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1200: consecutive synchronized-lock cycles required before release (100 us).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 120000: maximum wait for lock per attempt (10 ms).
REQ-004 Parameter MAX_RETRIES, default 3: number of consecutive failed attempts that forces FAULT, range 1..15.
REQ-005 refclk  input  1  sole clock (12 MHz PLL reference); all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL locked flag, asynchronous to refclk.
REQ-008 rearm  input  1  single-cycle pulse that clears FAULT and restarts the sequence.
REQ-009 pll_rst  output  1  drives the PLL rst input, active high.
REQ-010 sys_rst  output  1  active-high reset for logic clocked by the PLL outputs.
REQ-011 sys_ready  output  1  high while the PLL is locked and stable (RUN state).
REQ-012 fault  output  1  high in FAULT state.
REQ-013 lock_lost_cnt  output  8  saturating count of lock losses seen in RUN.
REQ-014 state_o  output  3  current state encoding, for debug.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer before use; lk_s denotes the synchronized value (2-cycle latency).
REQ-016 States SHALL be PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT; all outputs SHALL be registered.
REQ-017 PLL_RST: pll_rst=1 and sys_rst=1; after exactly RST_CYCLES cycles in this state, go to WAIT_LOCK with the cycle counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0 and sys_rst=1; lk_s=1 -> STABLE with the counter cleared.
REQ-019 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT_CYCLES-1 with lk_s=0, increment retry_cnt; if the new value equals MAX_RETRIES go to FAULT, otherwise go to PLL_RST.
REQ-020 STABLE: if lk_s stays 1 for LOCK_STABLE_CYCLES consecutive cycles, go to RUN; lk_s=0 at any point -> WAIT_LOCK with the timeout counter cleared and retry_cnt unchanged.
REQ-021 RUN: sys_rst=0, sys_ready=1, retry_cnt cleared on entry; lk_s=0 -> PLL_RST and lock_lost_cnt+1, saturating at 255.
REQ-022 FAULT: pll_rst=1, sys_rst=1, sys_ready=0, fault=1; the state is held until rearm=1, then go to PLL_RST with retry_cnt cleared and fault deasserted on the next cycle.
REQ-023 rearm SHALL be ignored in every state except FAULT.
REQ-024 Timing: if pll_locked rises at edge k during WAIT_LOCK and stays high, sys_ready SHALL rise at edge k+2+LOCK_STABLE_CYCLES (±1 for synchronizer phase).
REQ-025 sys_rst and sys_ready SHALL be exact complements in every cycle.
REQ-026 Counters SHALL be sized with clog2 of the largest of the cycle parameters and SHALL never wrap.

Reset
REQ-027 With rst=1: state=PLL_RST, counter=0, retry_cnt=0, lock_lost_cnt=0, synchronizer flops=0, pll_rst=1, sys_rst=1, sys_ready=0, fault=0.
REQ-028 rst asserted in any state, including mid-count or FAULT, SHALL take effect on the next edge and restart the full sequence.
REQ-029 After rst falls, pll_rst SHALL remain high for exactly RST_CYCLES cycles.

Structure
REQ-030 Package pll_sup_pkg SHALL hold the state encodings (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4) and the default parameter constants.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff; the FSM and counters SHALL live in pll_lock_supervisor.

Verification (RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-032 Normal lock: release rst, raise pll_locked 3 cycles after pll_rst falls -> pll_rst high for 4 cycles; sys_ready rises 10 (±1) cycles after pll_locked rises; lock_lost_cnt=0.
REQ-033 Glitch in STABLE: pll_locked high for 5 cycles, low for 1, then high -> state returns to WAIT_LOCK; sys_ready rises only after 8 clean cycles; retry_cnt unchanged.
REQ-034 Timeout to FAULT: pll_locked held low -> two PLL_RST pulses of 4 cycles, each followed by 32 cycles of WAIT_LOCK, then fault=1 with pll_rst=1 held; rearm pulse -> fault=0 and a new 4-cycle pll_rst pulse.
REQ-035 Lock loss in RUN: drop pll_locked while in RUN -> sys_ready falls 3 (±1) cycles later, pll_rst pulses for 4 cycles, lock_lost_cnt=1; repeat 300 times -> lock_lost_cnt saturates at 255.
REQ-036 Reset mid-operation: assert rst during STABLE and during FAULT -> next edge shows all REQ-027 values, followed by a fresh 4-cycle pll_rst pulse.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - state_t           : FSM state encodings (also exported on state_o)
//   - DEF_*             : default timing/retry parameters for a 12 MHz refclk
//   - max3()            : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned DEF_RST_CYCLES          = 32'd12;      // 1 us
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 32'd1200;    // 100 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd120000;  // 10 ms
  localparam int unsigned DEF_MAX_RETRIES         = 32'd3;

  // Largest of three values; sizes the single counter shared by all states.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Output lags the input by two rising edges.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input level
//   q   : synchronized output
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Synchronizer flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences a PLL through reset, lock acquisition and lock qualification,
// releases the downstream system reset only once lock has been stable, and
// falls into a latched FAULT state after too many failed attempts.
// Ports:
//   refclk        : PLL reference clock, sole clock of this block
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock flag (asynchronous, synchronized internally)
//   rearm         : one-cycle pulse, leaves FAULT and restarts the sequence
//   pll_rst       : PLL reset, active high
//   sys_rst       : reset for PLL-clocked logic, active high
//   sys_ready     : high in RUN (always the complement of sys_rst)
//   fault         : high in FAULT
//   lock_lost_cnt : saturating count of lock losses seen while in RUN
//   state_o       : current FSM state (debug)
// ---------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       rearm,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       sys_ready,
  output logic       fault,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_STABLE_CYCLES,
                                         LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 32'd1;

  // Terminal counts: the counter runs 0..N-1, so it never needs to hold N.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  logic             lk_s;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       retry_r, retry_s, retry_inc_s;
  logic [7:0]       lost_r, lost_s;
  logic             pll_rst_r, sys_rst_r, sys_ready_r, fault_r;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Next-state, counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    retry_s     = retry_r;
    lost_s      = lost_r;
    retry_inc_s = retry_r + 4'd1;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == RST_LAST) begin
          state_s = WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_s = STABLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == TO_LAST) begin
          cnt_s   = CNT_ZERO;
          retry_s = retry_inc_s;
          if (retry_inc_s == RETRY_LIMIT) begin
            state_s = FAULT;
          end else begin
            state_s = PLL_RST;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE: begin
        // A single dropout sends us back to waiting; the attempt is not
        // charged as a retry since the PLL did lock.
        if (!lk_s) begin
          state_s = WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = RUN;
          cnt_s   = CNT_ZERO;
          retry_s = 4'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_s = PLL_RST;
          cnt_s   = CNT_ZERO;
          if (lost_r != 8'hFF) begin
            lost_s = lost_r + 8'd1;
          end else begin
            lost_s = lost_r;
          end
        end else begin
          state_s = RUN;
        end
      end
      FAULT: begin
        if (rearm) begin
          state_s = PLL_RST;
          cnt_s   = CNT_ZERO;
          retry_s = 4'd0;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s = PLL_RST;
        cnt_s   = CNT_ZERO;
        retry_s = 4'd0;
      end
    endcase
  end

  // State/counter registers; outputs are decoded from the next state so the
  // registered outputs line up with state_r in every cycle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r     <= PLL_RST;
      cnt_r       <= CNT_ZERO;
      retry_r     <= 4'd0;
      lost_r      <= 8'd0;
      pll_rst_r   <= 1'b1;
      sys_rst_r   <= 1'b1;
      sys_ready_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      retry_r     <= retry_s;
      lost_r      <= lost_s;
      pll_rst_r   <= (state_s == PLL_RST) || (state_s == FAULT);
      sys_rst_r   <= (state_s != RUN);
      sys_ready_r <= (state_s == RUN);
      fault_r     <= (state_s == FAULT);
    end
  end

  assign pll_rst       = pll_rst_r;
  assign sys_rst       = sys_rst_r;
  assign sys_ready     = sys_ready_r;
  assign fault         = fault_r;
  assign lock_lost_cnt = lost_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int RSTC = 4;
  localparam int STBC = 8;
  localparam int TOC  = 32;
  localparam int MAXR = 2;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  // flags = {pll_rst, sys_rst, sys_ready, fault}
  localparam logic [3:0] F_RST  = 4'b1100;
  localparam logic [3:0] F_WAIT = 4'b0100;
  localparam logic [3:0] F_RUN  = 4'b0010;

  typedef struct {
    logic       r;
    logic       l;
    logic       ra;
    logic [3:0] flags;
    logic [2:0] st;
    logic [7:0] lost;
  } vec_t;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       rearm = 1'b0;
  logic       pll_rst, sys_rst, sys_ready, fault;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_o;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  pll_lock_supervisor #(
    .RST_CYCLES          (RSTC),
    .LOCK_STABLE_CYCLES  (STBC),
    .LOCK_TIMEOUT_CYCLES (TOC),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .rearm         (rearm),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .sys_ready     (sys_ready),
    .fault         (fault),
    .lock_lost_cnt (lock_lost_cnt),
    .state_o       (state_o)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic l, input logic ra);
    @(negedge refclk);
    rst = r;
    pll_locked = l;
    rearm = ra;
    @(posedge refclk);
    #1;
  endtask

  task automatic add(input logic r, input logic l, input logic ra,
                     input logic [3:0] fl, input logic [2:0] st, input logic [7:0] lost);
    vec_t v;
    v.r = r; v.l = l; v.ra = ra; v.flags = fl; v.st = st; v.lost = lost;
    vecs.push_back(v);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_state"}, int'(state_o), int'(S_RST));
    chk({nm, "_pll_rst"}, int'(pll_rst), 1);
    chk({nm, "_sys_rst"}, int'(sys_rst), 1);
    chk({nm, "_sys_ready"}, int'(sys_ready), 0);
    chk({nm, "_fault"}, int'(fault), 0);
    chk({nm, "_lost"}, int'(lock_lost_cnt), 0);
  endtask

  // After rst falls: pll_rst stays high 3 more samples, then WAIT_LOCK.
  task automatic check_fresh_pulse(input string nm, input logic l);
    for (int i = 0; i < RSTC - 1; i++) begin
      step(1'b0, l, 1'b0);
      chk({nm, "_pulse_hi"}, int'(pll_rst), 1);
    end
    step(1'b0, l, 1'b0);
    chk({nm, "_pulse_end"}, int'(pll_rst), 0);
    chk({nm, "_pulse_state"}, int'(state_o), int'(S_WAIT));
  endtask

  task automatic wait_state(input logic [2:0] st, input logic l, input int lim, input string nm);
    int k;
    k = 0;
    while (state_o != st && k < lim) begin
      step(1'b0, l, 1'b0);
      k++;
    end
    chk({nm, "_reached"}, int'(state_o), int'(st));
  endtask

  initial begin
    // ---------------- table: reset, normal lock, rearm ignored, lock loss
    add(1, 0, 0, F_RST,  S_RST,  0);
    add(1, 0, 0, F_RST,  S_RST,  0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, F_RST, S_RST, 0);
    add(0, 0, 0, F_WAIT, S_WAIT, 0);
    add(0, 0, 1, F_WAIT, S_WAIT, 0);          // rearm ignored in WAIT_LOCK
    add(0, 0, 0, F_WAIT, S_WAIT, 0);
    add(0, 1, 0, F_WAIT, S_WAIT, 0);          // lock rises 3 cycles after pll_rst fell
    add(0, 1, 0, F_WAIT, S_WAIT, 0);
    for (int i = 0; i < STBC; i++) add(0, 1, 0, F_WAIT, S_STB, 0);
    add(0, 1, 0, F_RUN,  S_RUN,  0);          // 10 cycles after the lock rise
    add(0, 1, 1, F_RUN,  S_RUN,  0);          // rearm ignored in RUN
    add(0, 0, 0, F_RUN,  S_RUN,  0);          // lock dropped
    add(0, 0, 0, F_RUN,  S_RUN,  0);
    for (int i = 0; i < RSTC; i++) add(0, 0, 0, F_RST, S_RST, 1);
    add(0, 0, 0, F_WAIT, S_WAIT, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].l, vecs[i].ra);
      chk($sformatf("vec%0d_flags", i), int'({pll_rst, sys_rst, sys_ready, fault}), int'(vecs[i].flags));
      chk($sformatf("vec%0d_state", i), int'(state_o), int'(vecs[i].st));
      chk($sformatf("vec%0d_lost", i), int'(lock_lost_cnt), int'(vecs[i].lost));
    end

    // ---------------- glitch in STABLE (starting from WAIT_LOCK)
    for (int i = 0; i < 17; i++) begin
      step(1'b0, (i < 5 || i >= 6) ? 1'b1 : 1'b0, 1'b0);
      if (i == 7)  chk("glitch_back_to_wait", int'(state_o), int'(S_WAIT));
      if (i == 8)  chk("glitch_restable", int'(state_o), int'(S_STB));
      if (i == 15) chk("glitch_not_ready_yet", int'(sys_ready), 0);
      if (i == 16) chk("glitch_ready", int'(sys_ready), 1);
    end
    chk("glitch_lost", int'(lock_lost_cnt), 1);

    // ---------------- timeout to FAULT, then rearm
    step(1'b1, 1'b0, 1'b0);
    check_reset_vals("to_reset");
    for (int i = 0; i < 72; i++) begin
      logic exp_pr;
      step(1'b0, 1'b0, 1'b0);
      exp_pr = (i <= 2) || (i >= 35 && i <= 38) || (i >= 71);
      chk($sformatf("to_pll_rst_c%0d", i), int'(pll_rst), int'(exp_pr));
      if (i == 70) chk("to_fault_before", int'(fault), 0);
      if (i == 71) chk("to_fault", int'(fault), 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("fault_hold", int'(state_o), int'(S_FLT));
      chk("fault_pll_rst", int'(pll_rst), 1);
      chk("fault_sys_ready", int'(sys_ready), 0);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("rearm_fault", int'(fault), 0);
    chk("rearm_state", int'(state_o), int'(S_RST));
    chk("rearm_pll_rst", int'(pll_rst), 1);
    check_fresh_pulse("rearm", 1'b0);

    // ---------------- lock loss saturation
    step(1'b1, 1'b0, 1'b0);
    check_reset_vals("sat_reset");
    for (int n = 0; n < 300; n++) begin
      wait_state(S_RUN, 1'b1, 60, "sat_run");
      wait_state(S_RST, 1'b0, 10, "sat_loss");
      if (n == 0)   chk("sat_lost_1", int'(lock_lost_cnt), 1);
      if (n == 253) chk("sat_lost_254", int'(lock_lost_cnt), 254);
      if (n == 254) chk("sat_lost_255", int'(lock_lost_cnt), 255);
      if (n == 299) chk("sat_lost_hold", int'(lock_lost_cnt), 255);
    end

    // ---------------- reset during STABLE (lock_lost_cnt is 255 here)
    wait_state(S_STB, 1'b1, 20, "mid_stable");
    step(1'b1, 1'b1, 1'b0);
    check_reset_vals("rst_in_stable");
    check_fresh_pulse("rst_in_stable", 1'b1);

    // ---------------- reset during FAULT
    wait_state(S_FLT, 1'b0, 200, "mid_fault");
    chk("mid_fault_flag", int'(fault), 1);
    step(1'b1, 1'b0, 1'b0);
    check_reset_vals("rst_in_fault");
    check_fresh_pulse("rst_in_fault", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
